uart_frame_decoder: RTL

Downstream consumer of the UART receiver byte stream (8-bit data plus single-cycle valid strobe). Delineates framed packets of the form SYNC, LEN, PAYLOAD[LEN], CHK. Checks length and XOR checksum, and buffers the payload for random-access readout. Reports each good frame with a one-cycle pulse, and each malformed or stalled frame with an error pulse and code.

---
 rtl/uart_frame_decoder.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_frame_decoder.sv
// UART frame decoder: finds SYNC, LEN, PAYLOAD[LEN], CHK frames in a received
// byte stream. It checks the length and the XOR checksum, and it stores the
// payload so it can be read back at any address.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   HUNT    | idle; waiting for SYNC_BYTE, other bytes dropped silently
//   LEN     | SYNC seen; next byte is the payload length
//   PAYLOAD | storing payload bytes and accumulating the checksum
//   CHECK   | all payload stored; next byte is compared with the checksum
//
// The checksum is seeded with the LEN byte. Every payload byte is XORed into it.
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         ADDR_W       = 4,
  parameter int         CLOCK_FREQ   = 12_000_000,
  parameter int         TIMEOUT_CLKS = CLOCK_FREQ / 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              frame_valid,
  output logic [7:0]        frame_len,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_error,
  output logic [1:0]        err_code,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT_CLKS + 1);
  // The buffer is indexed with the smallest width that covers MAX_LEN entries.
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [1:0] {
    S_HUNT    = 2'd0,
    S_LEN     = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       chk_q, chk_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             valid_d, error_d;
  logic [7:0]       frame_len_d;
  logic [1:0]       err_code_d;
  logic             timed_out;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [7:0]       wr_data;

  logic [7:0]       mem [2**IDX_W];

  // State register, frame bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HUNT;
      len_q       <= '0;
      count_q     <= '0;
      chk_q       <= '0;
      tmr_q       <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      frame_len   <= '0;
      err_code    <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      chk_q       <= chk_d;
      tmr_q       <= tmr_d;
      frame_valid <= valid_d;
      frame_error <= error_d;
      frame_len   <= frame_len_d;
      err_code    <= err_code_d;
      busy        <= (state_d != S_HUNT);
    end
  end

  // Next-state logic, datapath updates, pulse generation and the inter-byte timeout
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    chk_d       = chk_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    frame_len_d = frame_len;
    err_code_d  = err_code;
    wr_en       = 1'b0;
    wr_idx      = count_q[IDX_W-1:0];
    wr_data     = in_data;

    // A byte arriving in the expiry cycle wins over the timeout.
    timed_out = (state_q != S_HUNT) && !in_valid &&
                (tmr_q == TMR_W'(TIMEOUT_CLKS - 1));

    if ((state_q == S_HUNT) || in_valid || timed_out) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end

    unique case (state_q)
      S_HUNT: begin
        if (in_valid && (in_data == SYNC_BYTE)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (in_valid) begin
          if ((in_data == 8'd0) || (in_data > 8'(MAX_LEN))) begin
            error_d    = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = S_HUNT;
          end else begin
            len_d   = in_data;
            count_d = '0;
            chk_d   = in_data;
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (in_valid) begin
          wr_en   = 1'b1;
          chk_d   = chk_q ^ in_data;
          count_d = count_q + 8'd1;
          if (count_q == (len_q - 8'd1)) begin
            state_d = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        if (in_valid) begin
          state_d = S_HUNT;
          if (in_data == chk_q) begin
            valid_d     = 1'b1;
            frame_len_d = len_q;
          end else begin
            error_d    = 1'b1;
            err_code_d = ERR_CHK;
          end
        end
      end

      default: state_d = S_HUNT;
    endcase

    if (timed_out) begin
      error_d    = 1'b1;
      err_code_d = ERR_TMO;
      state_d    = S_HUNT;
      wr_en      = 1'b0;
    end
  end

  // Payload buffer writes; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Registered random-access readout; addresses past MAX_LEN read as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (int'(rd_addr) < MAX_LEN) begin
      rd_data <= mem[rd_addr[IDX_W-1:0]];
    end else begin
      rd_data <= '0;
    end
  end

endmodule
